udma_rxbuffer: RTL and testbench
================================

Name: udma_rxbuffer

Overview:
- Receive-side width adapter between the HyperBus PHY and the uDMA RX channel.
- Accepts 16-bit PHY read words and packs them byte-wise into 32-bit little-endian uDMA words.
- Applies the memory-space byte swap, drops the leading byte on odd start addresses, and trims and flushes to the exact byte count.
- Register-space reads pass the 16-bit value straight through, zero-extended.

Parameters:
TRANS_SIZE, 16, width of the byte-length configuration and the remaining-byte counter.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  single-cycle pulse; latches cfg_*, begins a transfer
abort_i  in  1  synchronous clear to IDLE; no output produced
cfg_len_i  in  TRANS_SIZE  bytes to deliver to uDMA (>=1)
cfg_odd_i  in  1  odd start address: discard first received byte
cfg_swap_i  in  1  1 = memory space: first byte is phy[15:8]; 0 = first byte is phy[7:0]
cfg_addr_space_i  in  1  1 = register space: pass-through mode
src_valid_i  in  1  PHY word valid
src_ready_o  out  1  buffer can accept a PHY word
src_data_i  in  16  PHY read word
dst_valid_o  out  1  32-bit word valid to uDMA
dst_ready_i  in  1  uDMA FIFO accepts
dst_data_o  out  32  packed word; byte0 in [7:0]
dst_last_o  out  1  qualifies the final word of the transfer
remained_o  out  TRANS_SIZE  bytes still to deliver
busy_o  out  1  high from start_i until done
done_o  out  1  one-cycle pulse after last word handshake

Behaviour:
- Reset: all outputs 0; state IDLE; accumulator count 0.
- States: IDLE -> RUN (on start_i) -> FLUSH -> DONE -> IDLE.
  - RUN: accept PHY words.
  - FLUSH: entered when remained_o equals the bytes held; drain without accepting.
  - DONE: asserts done_o for one cycle.
- start_i outside IDLE: ignored.
- abort_i: overrides everything, including a simultaneous start_i; returns to IDLE with count 0 next cycle.
- Accumulator: 6 bytes (48 bits) plus a 3-bit count.
- src_ready_o = (state==RUN) & (count<=4) & (bytes_wanted>count), where bytes_wanted = remained_o.
  - src_ready_o is a combinational function of registered state only; it never depends on src_valid_i.
- Push, on src_valid_i & src_ready_o:
  - Order the two incoming bytes per cfg_swap_i.
  - If the odd-drop is pending (cfg_odd_i latched, first word of the transfer), discard the first byte and clear the pending flag.
  - Append only as many bytes as still needed; excess bytes in the final PHY word are discarded.
- Pop, on dst_valid_o & dst_ready_i:
  - Remove min(4, count) bytes.
  - remained_o decrements by that amount.
  - Remaining bytes shift down.
- Simultaneous push and pop in the same cycle: count_next = count + pushed - popped.
- dst_valid_o (registered output stage; latency 1 cycle from the completing push) asserts when count>=4, or when count>0 and count==remained_o.
  - Partial word: unused upper bytes are 0.
- dst_last_o = dst_valid_o & (popped bytes == remained_o).
- dst_data_o and dst_valid_o hold stable while dst_valid_o & !dst_ready_i.
- Register space (cfg_addr_space_i latched 1): each accepted PHY word emits {16'b0, src_data_i} unswapped.
  - cfg_odd_i is ignored; cfg_len_i counts 2 per word.
- Throughput: sustains one PHY word per cycle with one uDMA word every 2 cycles under continuous ready.
- Boundary cases:
  - cfg_len_i==1 with odd: exactly one PHY word consumed; one word output containing phy's second byte.
  - cfg_len_i==0: treat as immediate DONE.
  - remained_o wraps never; saturates at 0.

Decomposition:
- Shared package hyper_rx_pkg holds:
  - the state enum (IDLE/RUN/FLUSH/DONE);
  - the ACC_BYTES=6 constant;
  - a byte-order function swap16.
- One natural sub-module: udma_rxbuffer_acc, the byte accumulator (push/pop count arithmetic and shift).
  - The top level holds the FSM, counters and output register.

Test Plan:
1. Swap on, even, len=4. PHY words 0xAABB, 0xCCDD -> one word 0xDDCCBBAA, dst_last_o=1, done_o pulse one cycle later.
2. Swap on, odd, len=5. PHY words 0x1122, 0x3344, 0x5566 -> words 0x55443322 then 0x00000066 with last; byte 0x11 dropped.
3. Backpressure. len=16, continuous PHY valid, dst_ready_i low for 5 cycles:
   - src_ready_o falls once count>4;
   - dst_data_o stays stable;
   - after release, four words are received in order with no loss or duplication.
4. Register space, len=2, PHY 0xBEEF -> dst_data_o 0x0000BEEF, last, no swap.
5. abort_i mid-transfer (after 1 of 4 words) -> next cycle busy_o=0, dst_valid_o=0, src_ready_o=0.
   - A fresh start_i then completes normally with correct data.
6. Reset asserted asynchronously mid-RUN -> all outputs 0 immediately; after release, state is IDLE with remained_o=0.

Source files
------------

// File: rtl/hyper_rx_pkg.sv
// Shared definitions for the HyperBus receive path: FSM encoding, accumulator
// depth and PHY byte-order helper.
package hyper_rx_pkg;

  localparam int unsigned AccBytes = 6;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // Returns the PHY word with the first-delivered byte in [7:0].
  function automatic logic [15:0] swap16(input logic [15:0] data, input logic swap);
    return swap ? {data[7:0], data[15:8]} : data;
  endfunction

endpackage

// File: rtl/udma_rxbuffer_acc.sv
// Byte accumulator: pops bytes off the bottom, appends new bytes above the
// survivors. Bytes above the count are always kept at zero.
module udma_rxbuffer_acc
  import hyper_rx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic [1:0]  push_n_i,
  input  logic [15:0] push_data_i,
  input  logic [2:0]  pop_n_i,
  output logic [31:0] head_d_o,
  output logic [2:0]  cnt_o,
  output logic [2:0]  cnt_d_o
);

  localparam int unsigned AccW = 8 * AccBytes;

  logic [AccW-1:0] acc_q, acc_d, shifted, ins;
  logic [2:0]      cnt_q, cnt_d, base;

  always_comb begin
    shifted = acc_q >> {pop_n_i, 3'b000};
    base    = cnt_q - pop_n_i;
    ins     = '0;
    if (push_i) begin
      ins[15:0] = (push_n_i == 2'd1) ? {8'h00, push_data_i[7:0]} : push_data_i;
    end
    acc_d = shifted | (ins << {base, 3'b000});
    cnt_d = base + (push_i ? {1'b0, push_n_i} : 3'd0);
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_d_o = acc_d[31:0];
  assign cnt_o    = cnt_q;
  assign cnt_d_o  = cnt_d;

endmodule

// File: rtl/udma_rxbuffer.sv
// RX width adapter: packs 16-bit HyperBus PHY words into 32-bit little-endian
// uDMA words, with odd-start drop, byte-count trim and register-space bypass.
module udma_rxbuffer
  import hyper_rx_pkg::*;
#(
  parameter int unsigned TRANS_SIZE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [TRANS_SIZE-1:0] cfg_len_i,
  input  logic                  cfg_odd_i,
  input  logic                  cfg_swap_i,
  input  logic                  cfg_addr_space_i,
  input  logic                  src_valid_i,
  output logic                  src_ready_o,
  input  logic [15:0]           src_data_i,
  output logic                  dst_valid_o,
  input  logic                  dst_ready_i,
  output logic [31:0]           dst_data_o,
  output logic                  dst_last_o,
  output logic [TRANS_SIZE-1:0] remained_o,
  output logic                  busy_o,
  output logic                  done_o
);

  logic [1:0]            state_q, state_d;
  logic [TRANS_SIZE-1:0] rem_q, rem_d;
  logic                  odd_q, odd_d, swap_q, swap_d, reg_q, reg_d;
  logic                  dst_valid_q, dst_valid_d, dst_last_q, dst_last_d;
  logic [31:0]           dst_data_q, dst_data_d;

  logic [2:0]            cnt_q, cnt_d, pop_cap, pop_avail, pop_n, out_cap, out_n;
  logic [31:0]           head_d;
  logic                  clr, push, hs;
  logic [15:0]           ordered, push_data;
  logic [1:0]            push_avail, push_n;
  logic [TRANS_SIZE-1:0] cnt_ext, cnt_d_ext, pop_ext, need, avail_ext, out_ext;

  assign cnt_ext     = {{(TRANS_SIZE-3){1'b0}}, cnt_q};
  assign cnt_d_ext   = {{(TRANS_SIZE-3){1'b0}}, cnt_d};
  assign pop_ext     = {{(TRANS_SIZE-3){1'b0}}, pop_n};
  assign src_ready_o = (state_q == StRun) && (cnt_q <= 3'd4) && (rem_q > cnt_ext);
  assign need        = rem_q - cnt_ext;
  assign push        = src_valid_i & src_ready_o & ~abort_i;
  assign hs          = dst_valid_q & dst_ready_i;
  assign clr         = abort_i | ((state_q == StIdle) & start_i);

  always_comb begin
    pop_cap   = reg_q ? 3'd2 : 3'd4;
    pop_avail = (cnt_q < pop_cap) ? cnt_q : pop_cap;
    pop_n     = hs ? pop_avail : 3'd0;

    ordered = swap16(src_data_i, swap_q & ~reg_q);
    if (odd_q) begin
      push_avail = 2'd1;
      push_data  = {8'h00, ordered[15:8]};
    end else begin
      push_avail = 2'd2;
      push_data  = ordered;
    end
    avail_ext = {{(TRANS_SIZE-2){1'b0}}, push_avail};
    // Trailing bytes beyond the requested length are dropped here.
    push_n = (need < avail_ext) ? need[1:0] : push_avail;
  end

  udma_rxbuffer_acc u_acc (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (clr),
    .push_i     (push),
    .push_n_i   (push_n),
    .push_data_i(push_data),
    .pop_n_i    (pop_n),
    .head_d_o   (head_d),
    .cnt_o      (cnt_q),
    .cnt_d_o    (cnt_d)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = (rem_q > pop_ext) ? (rem_q - pop_ext) : '0;
    odd_d   = odd_q & ~push;
    swap_d  = swap_q;
    reg_d   = reg_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          rem_d   = cfg_len_i;
          odd_d   = cfg_odd_i & ~cfg_addr_space_i;
          swap_d  = cfg_swap_i;
          reg_d   = cfg_addr_space_i;
          state_d = (cfg_len_i == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (rem_d == '0)            state_d = StDone;
        else if (rem_d == cnt_d_ext) state_d = StFlush;
      end
      StFlush: begin
        if (rem_d == '0) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
    if (abort_i) begin
      state_d = StIdle;
      rem_d   = '0;
      odd_d   = 1'b0;
    end
  end

  // Output register mirrors the next accumulator head, so it holds by itself
  // while the consumer stalls.
  always_comb begin
    out_cap     = reg_d ? 3'd2 : 3'd4;
    out_n       = (cnt_d < out_cap) ? cnt_d : out_cap;
    out_ext     = {{(TRANS_SIZE-3){1'b0}}, out_n};
    dst_valid_d = ((state_d == StRun) || (state_d == StFlush)) && (cnt_d != 3'd0) &&
                  ((cnt_d >= out_cap) || (cnt_d_ext == rem_d));
    dst_data_d  = '0;
    if (dst_valid_d) dst_data_d = reg_d ? {16'h0000, head_d[15:0]} : head_d;
    dst_last_d  = dst_valid_d && (out_ext == rem_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      odd_q       <= 1'b0;
      swap_q      <= 1'b0;
      reg_q       <= 1'b0;
      dst_valid_q <= 1'b0;
      dst_last_q  <= 1'b0;
      dst_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      odd_q       <= odd_d;
      swap_q      <= swap_d;
      reg_q       <= reg_d;
      dst_valid_q <= dst_valid_d;
      dst_last_q  <= dst_last_d;
      dst_data_q  <= dst_data_d;
    end
  end

  assign dst_valid_o = dst_valid_q;
  assign dst_data_o  = dst_data_q;
  assign dst_last_o  = dst_last_q;
  assign remained_o  = rem_q;
  assign busy_o      = (state_q == StRun) || (state_q == StFlush);
  assign done_o      = (state_q == StDone);

endmodule

// File: tb/tb_udma_rxbuffer.sv
// Scenario bench for udma_rxbuffer: expected uDMA words are queued per test and
// checked by a monitor as the DUT hands them over.
module tb_udma_rxbuffer;

  localparam int unsigned TS = 16;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic          start = 1'b0, abort = 1'b0, odd = 1'b0, swap = 1'b0, regsp = 1'b0;
  logic [TS-1:0] len = '0;
  logic          src_valid = 1'b0, dst_ready = 1'b1;
  logic [15:0]   src_data = '0;
  logic          src_ready, dst_valid, dst_last, busy, done;
  logic [31:0]   dst_data;
  logic [TS-1:0] remained;

  int n_cmp = 0, n_fail = 0, cyc = 0, last_cyc = -10;
  logic [32:0] exp_q[$];
  logic [15:0] phy_q[$];
  logic [32:0] e;

  udma_rxbuffer #(.TRANS_SIZE(TS)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .abort_i         (abort),
    .cfg_len_i       (len),
    .cfg_odd_i       (odd),
    .cfg_swap_i      (swap),
    .cfg_addr_space_i(regsp),
    .src_valid_i     (src_valid),
    .src_ready_o     (src_ready),
    .src_data_i      (src_data),
    .dst_valid_o     (dst_valid),
    .dst_ready_i     (dst_ready),
    .dst_data_o      (dst_data),
    .dst_last_o      (dst_last),
    .remained_o      (remained),
    .busy_o          (busy),
    .done_o          (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && dst_valid && dst_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL word_extra: got data %h last %b, required no word", dst_data, dst_last);
      end else begin
        e = exp_q.pop_front();
        if ({dst_last, dst_data} !== e) begin
          n_fail++;
          $display("FAIL word: got data %h last %b, required data %h last %b",
                   dst_data, dst_last, e[31:0], e[32]);
        end
      end
      if (dst_last) last_cyc = cyc;
    end
  end

  task automatic do_start(input logic [TS-1:0] l, input logic o, input logic s, input logic r);
    @(posedge clk); #1;
    len = l; odd = o; swap = s; regsp = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_phy();
    int guard = 0;
    logic hs;
    while (phy_q.size() != 0 && guard < 300) begin
      src_valid = 1'b1;
      src_data  = phy_q[0];
      @(negedge clk);
      hs = src_ready;
      @(posedge clk); #1;
      if (hs) void'(phy_q.pop_front());
      guard++;
    end
    src_valid = 1'b0;
    n_cmp++;
    if (phy_q.size() != 0) begin
      n_fail++;
      $display("FAIL phy_accept: got %0d words left unaccepted, required 0", phy_q.size());
      phy_q.delete();
    end
  endtask

  task automatic wait_done(input string name, input bit chk_lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 300);
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done_timeout: got done %b, required 1", name, done);
      return;
    end
    if (chk_lat) begin
      n_cmp++;
      if (cyc != last_cyc + 1) begin
        n_fail++;
        $display("FAIL %s_done_latency: got %0d cycles after last, required 1", name,
                 cyc - last_cyc);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_pulse: got done %b busy %b, required 0 0", name, done, busy);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_words_missing: got %0d outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({src_ready, dst_valid, dst_data, dst_last, remained, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy %b vld %b data %h last %b rem %0d busy %b done %b, required all 0",
               src_ready, dst_valid, dst_data, dst_last, remained, busy, done);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_swap_even();
    exp_q.push_back({1'b1, 32'hDDCCBBAA});
    phy_q = '{16'hAABB, 16'hCCDD};
    do_start(4, 1'b0, 1'b1, 1'b0);
    send_phy();
    wait_done("swap_even", 1'b1);
  endtask

  task automatic test_swap_odd();
    exp_q.push_back({1'b0, 32'h55443322});
    exp_q.push_back({1'b1, 32'h00000066});
    phy_q = '{16'h1122, 16'h3344, 16'h5566};
    do_start(5, 1'b1, 1'b1, 1'b0);
    send_phy();
    wait_done("swap_odd", 1'b1);
  endtask

  task automatic test_backpressure();
    dst_ready = 1'b0;
    for (int k = 0; k < 8; k++) phy_q.push_back({8'(2 * k + 1), 8'(2 * k)});
    for (int i = 0; i < 4; i++)
      exp_q.push_back({(i == 3), 8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)});
    do_start(16, 1'b0, 1'b0, 1'b0);
    fork
      send_phy();
      begin
        int n;
        logic [31:0] held;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!dst_valid && n < 50);
        held = dst_data;
        n_cmp++;
        if (src_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_ready_at_4: got %b, required 1", src_ready);
        end
        repeat (5) begin
          @(negedge clk);
          n_cmp++;
          if (dst_valid !== 1'b1 || dst_data !== 32'h03020100) begin
            n_fail++;
            $display("FAIL bp_stable: got vld %b data %h (first %h), required 1 03020100",
                     dst_valid, dst_data, held);
          end
        end
        n_cmp++;
        if (src_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_ready_full: got %b, required 0", src_ready);
        end
        @(posedge clk); #1 dst_ready = 1'b1;
      end
    join
    wait_done("backpressure", 1'b1);
  endtask

  task automatic test_reg_space();
    exp_q.push_back({1'b1, 32'h0000BEEF});
    phy_q = '{16'hBEEF};
    do_start(2, 1'b1, 1'b1, 1'b1);
    send_phy();
    wait_done("reg_space", 1'b1);
  endtask

  task automatic test_len_edges();
    exp_q.push_back({1'b1, 32'h00000022});
    phy_q = '{16'h1122};
    do_start(1, 1'b1, 1'b1, 1'b0);
    send_phy();
    wait_done("len1_odd", 1'b1);
    do_start(0, 1'b0, 1'b0, 1'b0);
    wait_done("len0", 1'b0);
  endtask

  task automatic test_abort();
    int n = 0;
    exp_q.push_back({1'b0, 32'h03020100});
    phy_q = '{16'h0100, 16'h0302, 16'h0504};
    do_start(16, 1'b0, 1'b0, 1'b0);
    send_phy();
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, dst_valid, src_ready} !== 3'b000 || remained !== '0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_clear: got busy %b vld %b rdy %b rem %0d pend %0d, required 0 0 0 0 0",
               busy, dst_valid, src_ready, remained, exp_q.size());
      exp_q.delete();
    end
    exp_q.push_back({1'b1, 32'h56781234});
    phy_q = '{16'h1234, 16'h5678};
    do_start(4, 1'b0, 1'b0, 1'b0);
    send_phy();
    wait_done("after_abort", 1'b1);
  endtask

  task automatic test_async_reset();
    dst_ready = 1'b0;
    phy_q = '{16'hAAAA, 16'hBBBB};
    do_start(8, 1'b0, 1'b0, 1'b0);
    send_phy();
    @(negedge clk);
    n_cmp++;
    if (dst_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: got vld %b busy %b, required 1 1", dst_valid, busy);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({src_ready, dst_valid, dst_data, dst_last, remained, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL arst_outputs: got rdy %b vld %b data %h rem %0d busy %b, required all 0",
               src_ready, dst_valid, dst_data, remained, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    dst_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, src_ready, dst_valid} !== 3'b000 || remained !== '0) begin
      n_fail++;
      $display("FAIL arst_idle: got busy %b rdy %b vld %b rem %0d, required 0 0 0 0",
               busy, src_ready, dst_valid, remained);
    end
  endtask

  initial begin
    test_reset();
    test_swap_even();
    test_swap_odd();
    test_backpressure();
    test_reg_space();
    test_len_edges();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
